// File: rtl/poly_arith_pkg.sv
// rtl/poly_arith_pkg.sv - shared modulus and coefficient type for polynomial arithmetic
package poly_arith_pkg;
    parameter int unsigned Q = 3329;
    typedef logic [11:0] coeff_t;
endpackage

// File: rtl/mod_addsub_vec.sv
// rtl/mod_addsub_vec.sv - LANES-wide modular add/sub, two-stage valid/ready pipeline
// Optional range-error flag enabled by macro MOD_ADDSUB_RANGE_CHECK_EN.
module mod_addsub_vec
    import poly_arith_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  coeff_t [LANES-1:0]   op1_i,
    input  coeff_t [LANES-1:0]   op2_i,
    input  logic                 sub_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output coeff_t [LANES-1:0]   result_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 err_o
);

    localparam logic [12:0] Q13 = 13'(Q);

    logic                   s1_valid_q;
    logic                   s1_sub_q;
    logic                   s1_err_q;
    logic [LANES-1:0][12:0] s1_raw_q;
    logic [LANES-1:0][12:0] s1_raw_d;
    logic                   s1_err_d;

    logic                   s2_valid_q;
    logic                   s2_err_q;
    coeff_t [LANES-1:0]     s2_res_q;
    coeff_t [LANES-1:0]     s2_res_d;

    logic                   s1_adv;
    logic                   s2_adv;

    // Stage 2 frees up when empty or draining; stage 1 may load when it can hand off.
    assign s2_adv  = !s2_valid_q || ready_i;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign ready_o = s1_adv;

    always_comb begin
        s1_raw_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (sub_i)
                s1_raw_d[l] = {1'b0, op1_i[l]} - {1'b0, op2_i[l]};
            else
                s1_raw_d[l] = {1'b0, op1_i[l]} + {1'b0, op2_i[l]};
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    localparam coeff_t Q12 = coeff_t'(Q);

    always_comb begin
        s1_err_d = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (op1_i[l] >= Q12 || op2_i[l] >= Q12)
                s1_err_d = 1'b1;
        end
    end
`else
    assign s1_err_d = 1'b0;
`endif

    // Negative difference shows up as bit 12 set in the 13-bit two's complement raw value.
    always_comb begin
        s2_res_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (s1_sub_q)
                s2_res_d[l] = s1_raw_q[l][12] ? 12'(s1_raw_q[l] + Q13) : s1_raw_q[l][11:0];
            else
                s2_res_d[l] = (s1_raw_q[l] >= Q13) ? 12'(s1_raw_q[l] - Q13) : s1_raw_q[l][11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= valid_i;
                if (valid_i) begin
                    s1_raw_q <= s1_raw_d;
                    s1_sub_q <= sub_i;
                    s1_err_q <= s1_err_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_q <= s2_res_d;
                    s2_err_q <= s1_err_q;
                end
            end
        end
    end

    assign result_o = s2_res_q;
    assign valid_o  = s2_valid_q;
    assign err_o    = s2_err_q;

endmodule

// File: tb/tb_mod_addsub_vec.sv
// tb/tb_mod_addsub_vec.sv - randomized and directed self-checking bench for mod_addsub_vec
module tb_mod_addsub_vec;

    localparam int LANES = 4;
    localparam int QM    = 3329;

    typedef logic [LANES-1:0][11:0] vec_t;
    typedef struct {
        vec_t res;
        logic err;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    vec_t op1_i, op2_i;
    logic sub_i, valid_i, ready_o, valid_o, ready_i, err_o;
    vec_t result_o;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    mod_addsub_vec #(.LANES(LANES)) dut (
        .clk      (clk),
        .rst      (rst),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .sub_i    (sub_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .result_o (result_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input vec_t a, input vec_t b, input logic s);
        exp_t m;
        m.res = '0;
        m.err = 1'b0;
        m.acc = 0;
        for (int l = 0; l < LANES; l++) begin
            int x, y, r;
            x = int'(a[l]);
            y = int'(b[l]);
            if (!s) begin
                r = x + y;
                if (r >= QM) r = r - QM;
            end else begin
                r = x - y;
                if (r < 0) r = r + QM;
            end
            m.res[l] = 12'(r);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
            if (x >= QM || y >= QM) m.err = 1'b1;
`endif
        end
        return m;
    endfunction

    function automatic vec_t pack4(input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v[0] = 12'(a0);
        v[1] = 12'(a1);
        v[2] = 12'(a2);
        v[3] = 12'(a3);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < LANES; l++) begin
            case ($urandom_range(0, 5))
                0:       v[l] = 12'd0;
                1:       v[l] = 12'(QM - 1);
                default: v[l] = 12'($urandom_range(0, QM - 1));
            endcase
        end
        return v;
    endfunction

    // One clock: drive at negedge, check 1 ns later against the queue model.
    task automatic step(input logic v, input logic s, input vec_t a, input vec_t b, input logic rdy);
        logic exp_valid, exp_ready;
        exp_t e;
        @(negedge clk);
        valid_i = v;
        sub_i   = s;
        op1_i   = a;
        op2_i   = b;
        ready_i = rdy;
        #1;
        exp_ready = (sb.size() < 2) || rdy;
        exp_valid = (sb.size() > 0) && (cyc - sb[0].acc >= 2);
        chk("ready_o", 64'(ready_o), 64'(exp_ready));
        chk("valid_o", 64'(valid_o), 64'(exp_valid));
        if (exp_valid) begin
            chk("result_o", 64'(result_o), 64'(sb[0].res));
            chk("err_o", 64'(err_o), 64'(sb[0].err));
            if (rdy) void'(sb.pop_front());
        end
        if (v && exp_ready) begin
            e = model(a, b, s);
            e.acc = cyc;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_vec(), rand_vec(), rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_result_o", 64'(result_o), 64'd0);
        chk("rst_err_o", 64'(err_o), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        cyc++;
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        sub_i   = 1'b0;
        ready_i = 1'b0;
        op1_i   = '0;
        op2_i   = '0;
        do_reset();

        step(1'b1, 1'b0, pack4(10, 3328, 3000, 0), pack4(20, 1, 3000, 0), 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b1, pack4(5, 10, 0, 3328), pack4(10, 5, 3328, 3328), 1'b1);
        idle(2, 1'b1);
        chk("sb_empty_directed", 64'(sb.size()), 64'd0);

        for (int i = 0; i < 8; i++) step(1'b1, 1'(i % 2), rand_vec(), rand_vec(), 1'b1);
        idle(3, 1'b1);

        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), rand_vec(), rand_vec(), 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);
        chk("sb_empty_backpressure", 64'(sb.size()), 64'd0);

        step(1'b1, 1'b0, rand_vec(), rand_vec(), 1'b0);
        step(1'b1, 1'b1, rand_vec(), rand_vec(), 1'b0);
        do_reset();
        idle(4, 1'b1);

        step(1'b1, 1'b0, pack4(7, 8, 3329, 9), pack4(1, 2, 3, 4), 1'b1);
        step(1'b1, 1'b1, pack4(7, 8, 100, 9), pack4(1, 2, 3, 4), 1'b1);
        idle(3, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            vec_t a, b;
            a = rand_vec();
            b = rand_vec();
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
            if ($urandom_range(0, 15) == 0) a[$urandom_range(0, LANES - 1)] = 12'($urandom_range(QM, 4095));
`endif
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, b,
                 1'($urandom_range(0, 3) != 0));
        end
        idle(4, 1'b1);
        chk("sb_empty_final", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
